// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Operands are captured on accept; the result is held until the consumer takes it or Flush discards it.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      Funct3,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic [1:0]      dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Input side accepts only in IDLE without Flush; output side holds Result/OutValid
  // stable until OutReady, and Flush voids any transfer in the same cycle.

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] absb_q;
  logic            sign_q;
  logic            sign_r;
  logic            sel_rem;

  logic            signed_op;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            b_zero;
  logic            ovf;
  logic            accept;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;
  logic            unused_f3;

  assign unused_f3 = Funct3[2];
  assign InReady   = (state == IDLE) && !Flush;
  assign accept    = InValid && InReady;
  assign dbg_state = state;

  always_comb begin
    signed_op = ~Funct3[0];
    sign_a    = signed_op & SrcA[XLEN-1];
    sign_b    = signed_op & SrcB[XLEN-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    abs_a     = sign_a ? (~SrcA + ONE) : SrcA;
    abs_b     = sign_b ? (~SrcB + ONE) : SrcB;
    b_zero    = (SrcB == '0);
    ovf       = signed_op && (SrcA == MIN_NEG) && (SrcB == '1);
    // Partial remainder is always below |B|, so XLEN+1 bits hold the shift and the trial.
    shifted   = {rem_q, quo_q[XLEN-1]};
    trial     = shifted - {1'b0, absb_q};
    fix_quo   = sign_q ? (~quo_q + ONE) : quo_q;
    fix_rem   = sign_r ? (~rem_q + ONE) : rem_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      absb_q   <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      sel_rem  <= 1'b0;
      Result   <= '0;
      OutValid <= 1'b0;
    end else if (Flush) begin
      state    <= IDLE;
      OutValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_rem <= Funct3[1];
            sign_q  <= sign_a ^ sign_b;
            sign_r  <= sign_a;
            absb_q  <= abs_b;
            if (b_zero) begin
              Result   <= Funct3[1] ? SrcA : '1;
              OutValid <= 1'b1;
              state    <= DONE;
            end else if (ovf) begin
              Result   <= Funct3[1] ? '0 : SrcA;
              OutValid <= 1'b1;
              state    <= DONE;
            end else begin
              cnt   <= '0;
              rem_q <= '0;
              quo_q <= abs_a;
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (!trial[XLEN]) begin
            rem_q <= trial[XLEN-1:0];
          end else begin
            rem_q <= shifted[XLEN-1:0];
          end
          quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= FIX;
          end
        end
        FIX: begin
          Result   <= sel_rem ? fix_rem : fix_quo;
          OutValid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          OutValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a vector table of single operations plus hand-built
// sequences for backpressure, flush and asynchronous reset.
module tb_div_iter;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         Flush;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [2:0]   Funct3;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic [1:0]   dbg_state;

  div_iter #(.XLEN(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Flush     (Flush),
    .InValid   (InValid),
    .InReady   (InReady),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Funct3    (Funct3),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Result    (Result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   f;
    logic [W-1:0] exp;
    int           lat;
    string        name;
  } vec_t;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  vec_t         vecs[14];
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // driver: present one operation, hold it across one rising edge, then scramble the inputs
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!InReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    SrcA    = a;
    SrcB    = b;
    Funct3  = f;
    InValid = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    SrcA    = $urandom;
    SrcB    = $urandom;
    Funct3  = 3'($urandom_range(0, 7));
  endtask

  // counts negedges after the accept edge until OutValid; also reports InReady leaking high
  task automatic wait_out(output int lat, output bit busy_bad);
    lat = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (InReady) busy_bad = 1'b1;
    end while (!OutValid && lat < 100);
  endtask

  task automatic watch_idle(input int n, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (OutValid) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    int           lat;
    bit           busy_bad;
    logic [W-1:0] exp;
    exp_q.push_back(v.exp);
    issue(v.a, v.b, v.f);
    wait_out(lat, busy_bad);
    exp = exp_q.pop_front();
    check({v.name, " result"}, Result, exp);
    check({v.name, " latency"}, W'(lat), W'(v.lat));
    check({v.name, " busy InReady"}, {31'd0, busy_bad}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({v.name, " post OutValid/InReady"}, {30'd0, OutValid, InReady}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  busy_bad;
    bit  stable_bad;
    vec_t v;

    vecs[0]  = '{32'd100,      32'd7,          F_DIVU, 32'd14,         34, "divu 100/7"};
    vecs[1]  = '{32'd100,      32'd7,          F_REMU, 32'd2,          34, "remu 100/7"};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,          F_DIV,  32'hFFFFFFFD,   34, "div -7/2"};
    vecs[3]  = '{32'hFFFFFFF9, 32'd2,          F_REM,  32'hFFFFFFFF,   34, "rem -7/2"};
    vecs[4]  = '{32'd7,        32'hFFFFFFFE,   F_DIV,  32'hFFFFFFFD,   34, "div 7/-2"};
    vecs[5]  = '{32'd7,        32'hFFFFFFFE,   F_REM,  32'h00000001,   34, "rem 7/-2"};
    vecs[6]  = '{32'd5,        32'd0,          F_DIV,  32'hFFFFFFFF,   1,  "div 5/0"};
    vecs[7]  = '{32'd5,        32'd0,          F_REMU, 32'd5,          1,  "remu 5/0"};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF,   F_DIV,  32'h80000000,   1,  "div min/-1"};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF,   F_REM,  32'h00000000,   1,  "rem min/-1"};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF,   F_DIVU, 32'h00000000,   34, "divu 0x8.../0xF..."};
    vecs[11] = '{32'h80000000, 32'hFFFFFFFF,   F_REMU, 32'h80000000,   34, "remu 0x8.../0xF..."};
    vecs[12] = '{32'hFFFFFF9C, 32'hFFFFFFF9,   F_DIV,  32'd14,         34, "div -100/-7"};
    vecs[13] = '{32'hFFFFFF9C, 32'hFFFFFFF9,   F_REM,  32'hFFFFFFFE,   34, "rem -100/-7"};

    reset_n  = 1'b0;
    Flush    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    SrcA     = '0;
    SrcB     = '0;
    Funct3   = '0;
    repeat (3) @(negedge clk);
    check("reset OutValid", {31'd0, OutValid}, 32'd0);
    check("reset InReady", {31'd0, InReady}, 32'd1);
    check("reset Result", Result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // backpressure: result held for 5 cycles, a stray InValid is ignored
    OutReady = 1'b0;
    issue(32'd100, 32'd7, F_DIVU);
    wait_out(lat, busy_bad);
    check("bp result", Result, 32'd14);
    check("bp latency", W'(lat), 32'd34);
    stable_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        SrcA = 32'd9; SrcB = 32'd3; Funct3 = F_DIVU; InValid = 1'b1;
      end
      if (i == 3) InValid = 1'b0;
      @(negedge clk);
      if (OutValid !== 1'b1 || Result !== 32'd14 || InReady !== 1'b0) stable_bad = 1'b1;
    end
    InValid = 1'b0;
    check("bp hold stable", {31'd0, stable_bad}, 32'd0);
    OutReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp post OutValid/InReady", {30'd0, OutValid, InReady}, 32'd1);
    watch_idle(40, "bp stray op ignored");

    // flush on the 10th ITER cycle
    issue(32'h0000FFFF, 32'd3, F_DIVU);
    repeat (9) @(posedge clk);
    #1 Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    @(negedge clk);
    check("flush OutValid/InReady", {30'd0, OutValid, InReady}, 32'd1);
    watch_idle(40, "flush no result");
    v = '{32'hFFFFFFFF, 32'h10, F_DIVU, 32'h0FFFFFFF, 34, "divu after flush"};
    run_op(v);

    // flush and InValid together: no accept
    @(negedge clk);
    SrcA = 32'd50; SrcB = 32'd5; Funct3 = F_DIVU;
    InValid = 1'b1;
    Flush   = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    Flush   = 1'b0;
    watch_idle(40, "flush beats InValid");

    // asynchronous reset mid-ITER
    issue(32'd1000, 32'hFFFFFFFD, F_DIV);
    repeat (10) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async reset OutValid/InReady", {30'd0, OutValid, InReady}, 32'd1);
    check("async reset Result", Result, 32'd0);
    #1 reset_n = 1'b1;
    watch_idle(40, "reset no result");
    v = '{32'd1000, 32'hFFFFFFFD, F_DIV, 32'hFFFFFEB3, 34, "div 1000/-3"};
    run_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
